// File: rtl/cam_rd_mux.sv
// cam_rd_mux: registered N:1 CAM entry read mux with single-read and wrapping scan modes
module cam_rd_mux #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 32,
    parameter int SEL_W     = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_SIZE*DEPTH-1:0] d_i,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_mode,
    input  logic [SEL_W-1:0]           req_sel,
    input  logic [SEL_W:0]             req_len,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_SIZE-1:0]       d_o,
    output logic [SEL_W-1:0]           out_idx,
    output logic                       out_last,
    output logic                       out_err,
    output logic                       busy
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t               state_q, state_d;
    logic [SEL_W-1:0]     cur_idx_q, cur_idx_d, idx_q, idx_d, ld_idx, nxt_idx;
    logic [SEL_W:0]       rem_q, rem_d, ld_rem, len_eff;
    logic [DATA_SIZE-1:0] d_q, d_d, ld_word;
    logic                 valid_q, valid_d, last_q, last_d, err_q, err_d;
    logic                 hit, load;

    // The first beat loads on the accept edge itself, so IDLE feeds the request fields straight in.
    assign len_eff   = (req_len == '0 || req_len > (SEL_W+1)'(DEPTH)) ? (SEL_W+1)'(DEPTH) : req_len;
    assign req_ready = rst_n && state_q == IDLE && (!valid_q || out_ready);
    assign ld_idx    = state_q == IDLE ? req_sel : cur_idx_q;
    assign ld_rem    = state_q == IDLE ? (req_mode ? len_eff : (SEL_W+1)'(1)) : rem_q;
    assign load      = state_q == IDLE ? (req_valid && req_ready) : (!valid_q || out_ready);
    assign nxt_idx   = (!hit || ld_idx == SEL_W'(DEPTH-1)) ? '0 : ld_idx + SEL_W'(1);

    // Entry lookup; an index with no matching entry is out of range and reads as zero.
    always_comb begin
        ld_word = '0;
        hit     = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ld_idx == SEL_W'(k)) begin
                ld_word = d_i[k*DATA_SIZE +: DATA_SIZE];
                hit     = 1'b1;
            end
        end
    end

    // Next state: load a beat whenever the output register is empty or draining.
    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        rem_d     = rem_q;
        d_d       = d_q;
        idx_d     = idx_q;
        valid_d   = valid_q && !out_ready;
        last_d    = last_q;
        err_d     = err_q;
        if (load) begin
            cur_idx_d = nxt_idx;
            rem_d     = ld_rem - (SEL_W+1)'(1);
            state_d   = ld_rem == (SEL_W+1)'(1) ? IDLE : RUN;
            d_d       = ld_word;
            idx_d     = ld_idx;
            valid_d   = 1'b1;
            last_d    = ld_rem == (SEL_W+1)'(1);
            err_d     = !hit;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_idx_q <= '0;
            rem_q     <= '0;
            d_q       <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_idx_q <= cur_idx_d;
            rem_q     <= rem_d;
            d_q       <= d_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign d_o       = d_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign out_err   = err_q;
    assign busy      = state_q == RUN;
endmodule

// File: tb/tb_cam_rd_mux.sv
// tb_cam_rd_mux: directed checks of cam_rd_mux at DEPTH=32 and DEPTH=24
module tb_cam_rd_mux;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [1023:0]  a_d;
    logic           a_req_valid, a_req_ready, a_mode, a_out_valid, a_out_ready, a_last, a_err, a_busy;
    logic [4:0]     a_sel, a_idx;
    logic [5:0]     a_len;
    logic [31:0]    a_do;
    logic [767:0]   b_d;
    logic           b_req_valid, b_req_ready, b_mode, b_out_valid, b_out_ready, b_last, b_err, b_busy;
    logic [4:0]     b_sel, b_idx;
    logic [5:0]     b_len;
    logic [31:0]    b_do;
    int             n_vec = 0, n_err = 0, hs;

    cam_rd_mux #(.DATA_SIZE(32), .DEPTH(32)) u_a (
        .clk(clk), .rst_n(rst_n), .d_i(a_d), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_mode(a_mode), .req_sel(a_sel), .req_len(a_len), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .d_o(a_do), .out_idx(a_idx), .out_last(a_last),
        .out_err(a_err), .busy(a_busy)
    );

    cam_rd_mux #(.DATA_SIZE(32), .DEPTH(24)) u_b (
        .clk(clk), .rst_n(rst_n), .d_i(b_d), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_mode(b_mode), .req_sel(b_sel), .req_len(b_len), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .d_o(b_do), .out_idx(b_idx), .out_last(b_last),
        .out_err(b_err), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) a_d[k*32 +: 32] = 32'hA000_0000 + k;
        for (int k = 0; k < 24; k++) b_d[k*32 +: 32] = 32'hB000_0000 + k;
        rst_n = 1'b0;
        a_req_valid = 1'b1; a_mode = 1'b0; a_sel = '0; a_len = '0; a_out_ready = 1'b1;
        b_req_valid = 1'b0; b_mode = 1'b0; b_sel = '0; b_len = '0; b_out_ready = 1'b1;
        #1;
        chk("rst_ready_t0", a_req_ready, 0);
        repeat (2) begin
            step;
            chk("rst_ready", a_req_ready, 0);
        end
        chk("rst_valid", a_out_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_do", a_do, 0);
        rst_n = 1'b1;
        a_req_valid = 1'b0;
        step;

        a_req_valid = 1'b1; a_mode = 1'b0; a_sel = 5'd17; a_len = 6'd5;
        chk("single_ready", a_req_ready, 1);
        step;
        a_req_valid = 1'b0;
        chk("single_valid", a_out_valid, 1);
        chk("single_do", a_do, 32'hA000_0011);
        chk("single_idx", a_idx, 17);
        chk("single_last", a_last, 1);
        chk("single_err", a_err, 0);
        chk("single_busy", a_busy, 0);

        a_req_valid = 1'b1; a_mode = 1'b1; a_sel = 5'd30; a_len = 6'd4;
        chk("wrap_ready", a_req_ready, 1);
        step;
        a_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wrap_valid", a_out_valid, 1);
            chk("wrap_idx", a_idx, (30 + i) % 32);
            chk("wrap_do", a_do, 32'hA000_0000 + (30 + i) % 32);
            chk("wrap_last", a_last, i == 3);
            chk("wrap_busy", a_busy, i != 3);
            step;
        end
        chk("wrap_drop", a_out_valid, 0);

        a_out_ready = 1'b0;
        a_req_valid = 1'b1; a_mode = 1'b1; a_sel = 5'd0; a_len = 6'd3;
        step;
        a_req_valid = 1'b0;
        hs = 0;
        chk("bp_first_valid", a_out_valid, 1);
        chk("bp_first_idx", a_idx, 0);
        a_d[31:0] = 32'hDEAD_BEEF;
        repeat (5) begin
            step;
            chk("bp_hold_valid", a_out_valid, 1);
            chk("bp_hold_idx", a_idx, 0);
            chk("bp_hold_do", a_do, 32'hA000_0000);
            chk("bp_hold_last", a_last, 0);
            chk("bp_hold_ready", a_req_ready, 0);
        end
        a_d[31:0] = 32'hA000_0000;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", a_out_valid, 1);
            chk("bp_idx", a_idx, i);
            chk("bp_do", a_do, 32'hA000_0000 + i);
            chk("bp_last", a_last, i == 2);
            if (a_out_valid && a_out_ready) hs++;
            step;
        end
        chk("bp_drop", a_out_valid, 0);
        chk("bp_handshakes", hs, 3);

        a_req_valid = 1'b1; a_mode = 1'b1; a_sel = 5'd5; a_len = 6'd2;
        step;
        a_req_valid = 1'b0;
        chk("b2b_idx0", a_idx, 5);
        step;
        chk("b2b_idx1", a_idx, 6);
        chk("b2b_last1", a_last, 1);
        a_req_valid = 1'b1; a_mode = 1'b0; a_sel = 5'd9;
        chk("b2b_ready", a_req_ready, 1);
        step;
        a_req_valid = 1'b0;
        chk("b2b_new_valid", a_out_valid, 1);
        chk("b2b_new_idx", a_idx, 9);
        chk("b2b_new_do", a_do, 32'hA000_0009);
        chk("b2b_new_last", a_last, 1);
        step;
        chk("b2b_drop", a_out_valid, 0);

        a_req_valid = 1'b1; a_mode = 1'b1; a_sel = 5'd3; a_len = 6'd40;
        step;
        a_req_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("clamp_idx", a_idx, (3 + i) % 32);
            chk("clamp_last", a_last, i == 31);
            step;
        end
        chk("clamp_drop", a_out_valid, 0);

        a_req_valid = 1'b1; a_mode = 1'b1; a_sel = 5'd0; a_len = 6'd8;
        step;
        a_req_valid = 1'b0;
        chk("rs_idx0", a_idx, 0);
        step;
        chk("rs_idx1", a_idx, 1);
        step;
        chk("rs_idx2", a_idx, 2);
        rst_n = 1'b0;
        step;
        chk("rs_valid", a_out_valid, 0);
        chk("rs_do", a_do, 0);
        chk("rs_idx", a_idx, 0);
        chk("rs_last", a_last, 0);
        chk("rs_err", a_err, 0);
        chk("rs_busy", a_busy, 0);
        chk("rs_ready_low", a_req_ready, 0);
        rst_n = 1'b1;
        step;
        chk("rs_idle_valid", a_out_valid, 0);
        chk("rs_idle_busy", a_busy, 0);
        chk("rs_idle_ready", a_req_ready, 1);

        b_req_valid = 1'b1; b_mode = 1'b0; b_sel = 5'd30;
        step;
        b_req_valid = 1'b0;
        chk("oor_valid", b_out_valid, 1);
        chk("oor_err", b_err, 1);
        chk("oor_do", b_do, 0);
        chk("oor_idx", b_idx, 30);
        chk("oor_last", b_last, 1);
        b_req_valid = 1'b1; b_mode = 1'b1; b_sel = 5'd22; b_len = 6'd0;
        step;
        b_req_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            chk("d24_valid", b_out_valid, 1);
            chk("d24_idx", b_idx, (22 + i) % 24);
            chk("d24_do", b_do, 32'hB000_0000 + (22 + i) % 24);
            chk("d24_last", b_last, i == 23);
            chk("d24_err", b_err, 0);
            step;
        end
        chk("d24_drop", b_out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
